// File: rtl/xilinx_primitive_pkg.sv
// Shared types and helpers for the Xilinx primitive wrappers.
// The BRAM read latency is derived here so that every client computes it identically.
package xilinx_primitive_pkg;

  typedef enum logic {RD_IDLE, RD_ISSUE} bram_rd_state_e;

  function automatic int bram_rd_latency(input int do_reg);
    return 1 + do_reg;
  endfunction

endpackage

// File: rtl/xilinx_sync_fifo.sv
// Single-clock FIFO with arbitrary (non power-of-two) depth.
// The head word is presented combinationally; an empty FIFO drives zero.
module xilinx_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_wr && !w_rd)      r_cnt <= r_cnt + CNT_W'(1);
      else if (w_rd && !w_wr) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/xilinx_bram_burst_reader.sv
// Burst read engine for one port of a TDP BRAM: command in, valid/ready stream out.
// Issue is credit-limited so the output FIFO can always absorb every read in flight.
module xilinx_bram_burst_reader
  import xilinx_primitive_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16,
  parameter int DO_REG     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  output logic                  BRAM_EN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [3:0]            BRAM_WE,
  output logic                  BRAM_REGCE,
  output logic                  BRAM_RST,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST
);

  localparam int L     = bram_rd_latency(DO_REG);
  localparam int DEPTH = L + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  bram_rd_state_e        r_state;
  bram_rd_state_e        w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_occ;
  logic [L-1:0]          r_vld_p;
  logic [L-1:0]          r_last_p;
  logic                  r_en_d;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_credit;
  logic [CNT_W:0]        w_used;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH:0]   w_fifo_dout;

  assign w_used   = {1'b0, r_inflight} + {1'b0, r_occ};
  assign w_credit = (w_used < (CNT_W + 1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_cmd_ready = !RST;
        if (CMD_VALID && !RST) w_state_nxt = RD_ISSUE;
      end
      RD_ISSUE: begin
        if (w_credit && !RST) begin
          w_issue = 1'b1;
          if (r_rem == '0) w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  assign w_accept  = CMD_VALID && w_cmd_ready;
  assign CMD_READY = w_cmd_ready;
  assign BRAM_EN   = w_issue;
  assign BRAM_ADDR = r_addr;
  assign BRAM_WE   = 4'b0000;
  assign BRAM_RST  = RST;
  // Without the output register REGCE has no effect; hold it high outside reset.
  assign BRAM_REGCE = (DO_REG != 0) ? r_en_d : !RST;

  // Issue stage: FSM, address/length counters and the credit counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= RD_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= '0;
      r_occ      <= '0;
      r_en_d     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= w_issue;
      if (w_accept) begin
        r_addr <= CMD_ADDR;
        r_rem  <= CMD_LEN;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - LEN_WIDTH'(1);
      end
      if (w_issue && !w_push)      r_inflight <= r_inflight + CNT_W'(1);
      else if (w_push && !w_issue) r_inflight <= r_inflight - CNT_W'(1);
      if (w_push && !w_pop)        r_occ <= r_occ + CNT_W'(1);
      else if (w_pop && !w_push)   r_occ <= r_occ - CNT_W'(1);
    end
  end

  // Latency stage: {valid, last} travel alongside the BRAM read for L cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_p  <= '0;
      r_last_p <= '0;
    end else begin
      r_vld_p[0]  <= w_issue;
      r_last_p[0] <= w_issue && (r_rem == '0);
      for (int i = 1; i < L; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_last_p[i] <= r_last_p[i-1];
      end
    end
  end

  assign w_push = r_vld_p[L-1];
  assign w_pop  = !w_fifo_empty && M_READY;

  // Output stage: capture BRAM_DO with its last flag into the elastic buffer.
  xilinx_sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_out_fifo (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_push (w_push),
    .i_din  ({r_last_p[L-1], BRAM_DO}),
    .i_pop  (w_pop),
    .o_dout (w_fifo_dout),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  assign M_VALID = !w_fifo_empty;
  assign M_DATA  = w_fifo_dout[DATA_WIDTH-1:0];
  assign M_LAST  = w_fifo_dout[DATA_WIDTH];

  always_ff @(posedge CLK) begin
    if (!RST) assert (!(w_push && w_fifo_full && !w_pop));
  end

endmodule

// File: tb/tb_xilinx_bram_burst_reader.sv
// Bench for xilinx_bram_burst_reader: BRAM read-port model plus a queue scoreboard
// that expands each accepted command into its expected addresses and words.
module tb_xilinx_bram_burst_reader;

  localparam int DATA_WIDTH = 18;
  localparam int ADDR_WIDTH = 10;
  localparam int LEN_WIDTH  = 16;
  localparam int DO_REG     = 0;
  localparam int L          = 1 + DO_REG;
  localparam int DEPTH      = L + 2;
  localparam int MEMSZ      = 1 << ADDR_WIDTH;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [LEN_WIDTH-1:0]  CMD_LEN;
  logic                  BRAM_EN;
  logic [ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [3:0]            BRAM_WE;
  logic                  BRAM_REGCE;
  logic                  BRAM_RST;
  logic [DATA_WIDTH-1:0] BRAM_DO;
  logic                  M_VALID;
  logic                  M_READY;
  logic [DATA_WIDTH-1:0] M_DATA;
  logic                  M_LAST;

  xilinx_bram_burst_reader #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH(LEN_WIDTH), .DO_REG(DO_REG)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .BRAM_EN(BRAM_EN),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WE(BRAM_WE), .BRAM_REGCE(BRAM_REGCE),
    .BRAM_RST(BRAM_RST), .BRAM_DO(BRAM_DO), .M_VALID(M_VALID),
    .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM read port: address latched on EN, optional output register on REGCE.
  logic [DATA_WIDTH-1:0] mem [MEMSZ];
  logic [DATA_WIDTH-1:0] bram_lat = '0;
  logic [DATA_WIDTH-1:0] bram_oreg = '0;
  always @(posedge CLK) begin
    if (BRAM_RST) bram_lat <= '0;
    else if (BRAM_EN) bram_lat <= mem[BRAM_ADDR];
    if (BRAM_RST) bram_oreg <= '0;
    else if (BRAM_REGCE) bram_oreg <= bram_lat;
  end
  assign BRAM_DO = (DO_REG != 0) ? bram_oreg : bram_lat;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [DATA_WIDTH:0]   exp_q [$];
  logic [ADDR_WIDTH-1:0] exp_a [$];
  int n_en = 0;
  int n_pop = 0;
  int last_en_cyc = 0;
  bit rnd_ready = 0;

  always @(negedge CLK) begin : monitor
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH:0]   e;
    if (RST) begin
      exp_q.delete();
      exp_a.delete();
    end else begin
      if (BRAM_EN) begin
        n_en++;
        last_en_cyc = cyc;
        check("issue_expected", longint'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) check("bram_addr", longint'(BRAM_ADDR), longint'(exp_a.pop_front()));
      end
      if (M_VALID && M_READY) begin
        n_pop++;
        check("word_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("m_data", longint'(M_DATA), longint'(e[DATA_WIDTH-1:0]));
          check("m_last", longint'(M_LAST), longint'(e[DATA_WIDTH]));
        end
      end
      if (CMD_VALID && CMD_READY) begin
        for (int i = 0; i <= int'(CMD_LEN); i++) begin
          a = CMD_ADDR + ADDR_WIDTH'(i);
          exp_a.push_back(a);
          exp_q.push_back({(i == int'(CMD_LEN)), mem[a]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd_ready) M_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cmd(input int addr, input int len, output int acc_cyc);
    bit acc;
    int n;
    CMD_ADDR  = ADDR_WIDTH'(addr);
    CMD_LEN   = LEN_WIDTH'(len);
    CMD_VALID = 1'b1;
    acc = 0;
    n = 0;
    acc_cyc = -1;
    while (!acc && n < 2000) begin
      @(negedge CLK);
      acc = CMD_READY;
      if (acc) acc_cyc = cyc;
      tick();
      n++;
    end
    CMD_VALID = 1'b0;
    if (!acc) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_a.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check(tag, longint'(exp_q.size() + exp_a.size()), 0);
  endtask

  initial begin
    int ca, cb, n0;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_LEN = '0; M_READY = 1'b1;
    for (int i = 0; i < MEMSZ; i++) mem[i] = DATA_WIDTH'(i);

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", longint'(CMD_READY), 0);
    check("rst_bram_en", longint'(BRAM_EN), 0);
    check("rst_bram_addr", longint'(BRAM_ADDR), 0);
    check("rst_bram_regce", longint'(BRAM_REGCE), 0);
    check("rst_bram_we", longint'(BRAM_WE), 0);
    check("rst_bram_rst", longint'(BRAM_RST), 1);
    check("rst_m_valid", longint'(M_VALID), 0);
    check("rst_m_data", longint'(M_DATA), 0);
    check("rst_m_last", longint'(M_LAST), 0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", longint'(CMD_READY), 1);
    tick();

    // Basic burst: latency and back-to-back words
    send_cmd(5, 3, ca);
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK);
      check("t1_bram_en", longint'(BRAM_EN), longint'(j <= 4));
      check("t1_m_valid", longint'(M_VALID), longint'(j >= L + 2 && j <= L + 5));
      tick();
    end
    wait_drain("t1_drain");

    // Address wrap
    n0 = n_en;
    send_cmd(MEMSZ - 2, 3, ca);
    wait_drain("wrap_drain");
    check("wrap_issues", longint'(n_en - n0), 4);

    // Backpressure: issue stops at DEPTH, resumes after one pop
    M_READY = 1'b0;
    n0 = n_en;
    send_cmd(300, 15, ca);
    repeat (12) tick();
    check("bp_issues", longint'(n_en - n0), DEPTH);
    M_READY = 1'b1;
    @(negedge CLK);
    check("bp_stalled_en", longint'(BRAM_EN), 0);
    check("bp_valid", longint'(M_VALID), 1);
    tick();
    M_READY = 1'b0;
    @(negedge CLK);
    check("bp_resume_en", longint'(BRAM_EN), 1);
    tick();
    n0 = n_pop;
    rnd_ready = 1;
    wait_drain("bp_drain");
    check("bp_words", longint'(n_pop - n0), 15);
    rnd_ready = 0;
    M_READY = 1'b1;

    // Back-to-back commands
    send_cmd(0, 0, ca);
    send_cmd(100, 1, cb);
    check("b2b_final_issue", longint'(last_en_cyc), longint'(ca + 1));
    check("b2b_gap", longint'(cb - ca), 2);
    wait_drain("b2b_drain");

    // Reset mid-burst with two words buffered
    M_READY = 1'b0;
    send_cmd(400, 7, ca);
    repeat (3) tick();
    RST = 1'b1;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    M_READY = 1'b1;
    @(negedge CLK);
    check("rst_mid_valid", longint'(M_VALID), 0);
    check("rst_mid_ready", longint'(CMD_READY), 1);
    tick();
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      check("rst_no_stale", longint'(M_VALID), 0);
      tick();
    end
    send_cmd(200, 2, ca);
    wait_drain("rst_recover_drain");

    // Randomized bursts with random backpressure and random memory
    for (int i = 0; i < MEMSZ; i++) mem[i] = DATA_WIDTH'($urandom);
    rnd_ready = 1;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_cmd(int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(0, 12)), ca);
    end
    wait_drain("rand_drain");
    rnd_ready = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
